// File: rtl/mips_regfile_mp.sv
// Multi-read, dual-write MIPS register file with hardware clear sweep,
// hardwired-zero entry, write-to-read bypass and write-port conflict flag.
module mips_regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       init_req,
  output logic                       busy,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  output logic                       wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic idle;
  logic same_addr;
  logic wr0_ok, wr1_ok;
  logic conflict_d;

  assign busy = (state_q == ST_CLEAR);
  assign idle = (state_q == ST_IDLE);

  // Writes to entry 0 are dropped when it is hardwired; on a same-address
  // dual write port 1 is suppressed so port 0 wins.
  always_comb begin
    same_addr  = (wr0_addr == wr1_addr);
    wr0_ok     = idle && wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
    wr1_ok     = idle && wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0))
                 && !(wr0_en && same_addr);
    conflict_d = idle && wr0_en && wr1_en && same_addr
                 && !((ZERO_REG != 0) && (wr0_addr == '0));
  end

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (init_req) state_d = ST_CLEAR;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      wr_conflict <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      wr_conflict <= conflict_d;
    end
  end

  // NOTE: the storage array has no reset; the clear sweep zeroes it, which
  // keeps it mappable onto plain RAM/flop arrays without reset fan-out.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (wr1_ok) mem[wr1_addr] <= wr1_data;
      if (wr0_ok) mem[wr0_addr] <= wr0_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      if (busy)
        data = '0;
      else if ((ZERO_REG != 0) && (addr == '0))
        data = '0;
      else if ((BYPASS != 0) && wr0_en && (wr0_addr == addr))
        data = wr0_data;
      else if ((BYPASS != 0) && wr1_en && (wr1_addr == addr))
        data = wr1_data;
      else
        data = mem[addr];
    end

    assign rd_data[i*DATA_W +: DATA_W] = data;
  end

endmodule

// File: doc/mips_regfile_mp.md
Name: mips_regfile_mp

Overview:
- Parametrised multi-read, dual-write register file for the MIPS datapath. Generation 2 of the CPU register file.
- Adds: configurable width/depth/read-port count, hardwired-zero register, write-to-read bypass, write-port arbitration with conflict flag.
- Replaces preloaded contents with a hardware clear sweep run after reset or on request.
- Sits between decode (read ports) and writeback (write port 0 = ALU/WB, write port 1 = load/secondary return).

Parameters:
- DATA_W, 32, data width of each register.
- ADDR_W, 5, address width; depth DEPTH = 2^ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and writes to it are dropped.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_req  in  1  request a full clear sweep; sampled only in IDLE.
- busy  out  1  high while a clear sweep runs.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, same packing as rd_addr.
- wr0_en  in  1  write port 0 enable.
- wr0_addr  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 enable.
- wr1_addr  in  ADDR_W  write port 1 address.
- wr1_data  in  DATA_W  write port 1 data.
- wr_conflict  out  1  registered one-cycle pulse: both ports wrote the same address in the previous cycle.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous assert, active-low, synchronous deassert.
- Reset values:
  - FSM = CLEAR, clr_cnt = 0.
  - busy = 1, wr_conflict = 0.
  - Storage array is not asynchronously reset; it is zeroed by the sweep.
- FSM states: CLEAR, IDLE.
- CLEAR state:
  - Each rising edge writes 0 to entry clr_cnt, then clr_cnt increments.
  - After the edge that writes entry DEPTH-1, go to IDLE with clr_cnt = 0.
  - The sweep takes exactly DEPTH cycles after rst_n rises (32 at defaults).
  - busy = 1 throughout CLEAR.
  - wr0/wr1 are ignored, and wr_conflict stays 0.
  - All rd_data read 0.
  - init_req is ignored.
- IDLE state:
  - busy = 0.
  - init_req = 1 on an edge moves to CLEAR next cycle; busy rises the cycle after init_req is sampled.
  - Writes sampled in the same cycle as init_req are still performed.
- Reset mid-sweep: the FSM returns to CLEAR with clr_cnt = 0, and the sweep restarts from entry 0.
- Writes (IDLE only):
  - On the rising edge, each enabled port writes its data to its address.
  - If wr0_en and wr1_en target the same address, wr0 wins. wr_conflict = 1 for the following cycle only.
  - With ZERO_REG = 1:
    - Writes to address 0 are discarded.
    - A dual write to address 0 does not flag a conflict.
- Reads (combinational, zero latency, per port, in priority order):
  1. busy → 0.
  2. ZERO_REG and addr == 0 → 0.
  3. BYPASS and wr0_en and wr0_addr == addr → wr0_data.
  4. BYPASS and wr1_en and wr1_addr == addr → wr1_data.
  5. Otherwise → stored entry.
- BYPASS = 0: reads return the pre-edge stored value; the new value is visible the cycle after the write.
- Any number of read ports may read the same address simultaneously.
- No arithmetic. Addresses wrap naturally at ADDR_W bits; clr_cnt is ADDR_W+1 bits, or uses a terminal compare.

Test Plan:
- Reset and sweep:
  - Stimulus: hold rst_n = 0 for 3 cycles, release, write entries with random data, then pulse rst_n low again.
  - Required: busy = 1 for exactly 32 cycles after release, then 0. All 32 entries then read 0 on both ports. A second reset pulse mid-sweep (cycle 10) restarts the 32-cycle count.
- Basic write/read:
  - Stimulus: wr0 to addr 5 = 0xDEADBEEF; the next cycle, read port 0 at addr 5 and port 1 at addr 6.
  - Required: port 0 reads 0xDEADBEEF, port 1 reads 0x00000000.
- Bypass and zero register:
  - Stimulus: in the same cycle, wr1 to addr 7 = 0x12345678 and rd_addr[0] = 7; separately, wr0 to addr 0 = 0xFFFFFFFF.
  - Required: port 0 reads 0x12345678 that same cycle. Address 0 reads 0 forever after. With BYPASS = 0, the addr-7 read shows the old value that cycle.
- Write conflict:
  - Stimulus: in one cycle, wr0 and wr1 both to addr 9, with data 0xAAAA0000 and 0x5555FFFF.
  - Required: addr 9 reads 0xAAAA0000. wr_conflict = 1 for exactly the next cycle.
- Soft clear:
  - Stimulus: in IDLE, pulse init_req with a wr0 to addr 3 = 0x1 in the same cycle.
  - Required: busy rises the next cycle and lasts 32 cycles. Writes attempted during busy are dropped. Addr 3 reads 0 afterwards.
- Parameter sweep:
  - Stimulus: rerun the tests above with DATA_W = 64, ADDR_W = 3, NUM_RD = 4, ZERO_REG = 0.
  - Required: an 8-cycle sweep. Addr 0 is writable. All 4 read ports are independent.
